// File: rtl/cp_insert_if.sv
// Sample stream bundle between the IFFT, the cyclic-prefix inserter
// and the DA offset stage.
interface cp_insert_if #(
    parameter int WIDTH = 11
);
    logic             valid_i;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] xi;
    logic             rd_en;
    logic             valid_o;
    logic [WIDTH-1:0] yr;
    logic [WIDTH-1:0] yi;
    logic             sym_o;

    modport master (
        output valid_i, xr, xi,
        input  rd_en, valid_o, yr, yi, sym_o
    );

    modport slave (
        input  valid_i, xr, xi,
        output rd_en, valid_o, yr, yi, sym_o
    );
endinterface

// File: rtl/cp_insert.sv
// OFDM cyclic-prefix inserter: ping-pong symbol buffer, replays the
// last CP_LEN samples ahead of each full symbol.
module cp_insert #(
    parameter int WIDTH  = 11,
    parameter int NFFT   = 64,
    parameter int CP_LEN = 16
) (
    input logic        CLK,
    input logic        RST,
    cp_insert_if.slave bus
);
    localparam int AW = $clog2(NFFT);
    localparam logic [AW-1:0] CP_START = AW'(NFFT - CP_LEN);
    localparam logic [AW-1:0] LAST     = AW'(NFFT - 1);

    typedef enum logic [1:0] {
        IDLE,
        CP,
        BODY
    } state_t;

    state_t          state, state_n;
    logic [1:0]      full, full_n;
    logic            wbank;
    logic            rbank, rbank_n;
    logic [AW-1:0]   widx;
    logic [AW-1:0]   raddr, raddr_n;
    logic            accept, wlast;
    logic            rd, rdone, sym_n;

    logic [2*WIDTH-1:0] mem [2*NFFT];

    assign bus.rd_en = !full[wbank];
    assign accept    = bus.valid_i && !full[wbank];
    assign wlast     = accept && (widx == LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            widx  <= '0;
            wbank <= 1'b0;
        end else if (accept) begin
            widx <= wlast ? '0 : widx + AW'(1);
            if (wlast)
                wbank <= !wbank;
        end
    end

    // Storage carries no reset; the full flags gate every read.
    always_ff @(posedge CLK) begin
        if (accept)
            mem[{wbank, widx}] <= {bus.xr, bus.xi};
    end

    always_comb begin
        state_n = state;
        raddr_n = raddr;
        rbank_n = rbank;
        rd      = 1'b0;
        rdone   = 1'b0;
        unique case (state)
            IDLE: begin
                if (full[rbank]) begin
                    state_n = CP;
                    raddr_n = CP_START;
                end
            end
            CP: begin
                rd = 1'b1;
                if (raddr == LAST) begin
                    state_n = BODY;
                    raddr_n = '0;
                end else begin
                    raddr_n = raddr + AW'(1);
                end
            end
            BODY: begin
                rd = 1'b1;
                if (raddr == LAST) begin
                    rdone   = 1'b1;
                    rbank_n = !rbank;
                    // Chain straight into the next symbol if it is ready.
                    if (full[!rbank]) begin
                        state_n = CP;
                        raddr_n = CP_START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    raddr_n = raddr + AW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        full_n = full;
        if (wlast)
            full_n[wbank] = 1'b1;
        if (rdone)
            full_n[rbank] = 1'b0;
    end

    assign sym_n = (state == CP) && (raddr == CP_START);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            raddr <= '0;
            rbank <= 1'b0;
            full  <= '0;
        end else begin
            state <= state_n;
            raddr <= raddr_n;
            rbank <= rbank_n;
            full  <= full_n;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.valid_o <= 1'b0;
            bus.sym_o   <= 1'b0;
            bus.yr      <= '0;
            bus.yi      <= '0;
        end else begin
            bus.valid_o <= rd;
            bus.sym_o   <= sym_n;
            if (rd)
                {bus.yr, bus.yi} <= mem[{rbank, raddr}];
        end
    end
endmodule

// File: tb/tb_cp_insert.sv
// Directed bench for cp_insert: table of symbol runs checked against
// a reference buffer model, plus reset and CP_LEN=1 sequences.
module tb_cp_insert;
    localparam int W = 11;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] i;
        logic         s;
        int           e;
    } out_t;

    typedef struct {
        string name;
        int    nsym;
        int    pat;
        bit    gappy;
        bit    contig;
        int    exp_n;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;
    int   pos = 0;
    bit   stop_send = 1'b0;
    logic prst = 1'b0;
    logic [W-1:0] pyr = '0;
    logic [W-1:0] pyi = '0;

    logic [2*W-1:0] inq[$];
    int             acc_e[$];
    out_t           outq[$];
    out_t           outq1[$];

    cp_insert_if #(.WIDTH(W)) bus ();
    cp_insert_if #(.WIDTH(W)) bus1 ();

    assign bus1.valid_i = bus.valid_i;
    assign bus1.xr      = bus.xr;
    assign bus1.xi      = bus.xi;

    cp_insert #(.WIDTH(W), .NFFT(64), .CP_LEN(16)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    cp_insert #(.WIDTH(W), .NFFT(64), .CP_LEN(1)) dut1 (
        .CLK(CLK),
        .RST(RST),
        .bus(bus1)
    );

    always #5 CLK = !CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (RST && bus.valid_i && bus.rd_en) begin
            inq.push_back({bus.xr, bus.xi});
            acc_e.push_back(cyc + 1);
        end
        if (RST && bus.valid_i && !bus.rd_en)
            stall_cnt++;
        if (bus.valid_o) begin
            outq.push_back('{bus.yr, bus.yi, bus.sym_o, cyc});
            pos = bus.sym_o ? 0 : pos + 1;
            if (pos == 79)
                chk("rd_en_after_clear", 64'(bus.rd_en), 64'd1);
        end
        if (bus1.valid_o)
            outq1.push_back('{bus1.yr, bus1.yi, bus1.sym_o, cyc});
        if (RST && prst && !bus.valid_o)
            chk("hold", {42'd0, bus.yr, bus.yi}, {42'd0, pyr, pyi});
        prst = RST;
        pyr  = bus.yr;
        pyi  = bus.yi;
    end

    function automatic logic [2*W-1:0] samp(input int pat, input int idx);
        logic [W-1:0] r;
        logic [W-1:0] i;
        case (pat)
            0: begin
                r = W'(idx);
                i = W'(-idx);
            end
            1: begin
                r = idx[0] ? 11'h3FF : 11'h400;
                i = idx[0] ? 11'h400 : 11'h3FF;
            end
            default: begin
                r = W'($urandom);
                i = W'($urandom);
            end
        endcase
        return {r, i};
    endfunction

    task automatic clear_q();
        inq.delete();
        acc_e.delete();
        outq.delete();
        outq1.delete();
        stall_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        bus.valid_i = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        clear_q();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input int n, input int pat, input int base,
                        input bit gappy);
        int  t;
        bit  acc;
        for (int k = 0; k < n && !stop_send; k++) begin
            if (gappy && $urandom_range(0, 2) == 0) begin
                bus.valid_i = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge CLK);
                #1;
            end
            {bus.xr, bus.xi} = samp(pat, base + k);
            bus.valid_i = 1'b1;
            t   = 0;
            acc = 1'b0;
            while (!acc && !stop_send) begin
                @(negedge CLK);
                if (bus.rd_en)
                    acc = 1'b1;
                t++;
                @(posedge CLK);
                #1;
                if (!acc && t > 400) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: got rd_en=0 for %0d cycles expected 1", t);
                    bus.valid_i = 1'b0;
                    return;
                end
            end
        end
        bus.valid_i = 1'b0;
    endtask

    task automatic check_run(input string nm, input int nsym,
                             input bit contig, input int exp_n);
        int t;
        int a;
        int j;
        int lim;
        t = 0;
        while (outq.size() < exp_n && t < exp_n + 600) begin
            @(negedge CLK);
            t++;
        end
        repeat (120) @(negedge CLK);
        chk({nm, "_count"}, 64'(outq.size()), 64'(exp_n));
        if (outq.size() > 0 && acc_e.size() >= 64)
            chk({nm, "_latency"}, 64'(outq[0].e), 64'(acc_e[63] + 2));
        lim = outq.size() < exp_n ? outq.size() : exp_n;
        if (inq.size() < nsym * 64) begin
            checks++;
            errors++;
            $display("FAIL %s_inputs: got %0d accepted expected %0d",
                     nm, inq.size(), nsym * 64);
            lim = 0;
        end
        for (int k = 0; k < lim; k++) begin
            j = k % 80;
            a = j < 16 ? 48 + j : j - 16;
            chk({nm, "_data"},
                {41'd0, outq[k].r, outq[k].i, outq[k].s},
                {41'd0, inq[(k / 80) * 64 + a], 1'(j == 0)});
            if (k > 0 && (j != 0 || contig))
                chk({nm, "_contig"}, 64'(outq[k].e), 64'(outq[k-1].e + 1));
        end
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{"single",    1, 0, 1'b0, 1'b1,  80};
        tbl[1] = '{"b2b",       4, 0, 1'b0, 1'b1, 320};
        tbl[2] = '{"gappy",     2, 2, 1'b1, 1'b0, 160};
        tbl[3] = '{"extremes",  2, 1, 1'b0, 1'b1, 160};
        tbl[4] = '{"rand_b2b",  3, 2, 1'b0, 1'b1, 240};

        bus.valid_i = 1'b0;
        bus.xr = '0;
        bus.xi = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_valid_o", 64'(bus.valid_o), 64'd0);
        chk("rst_sym_o", 64'(bus.sym_o), 64'd0);
        chk("rst_yr", 64'(bus.yr), 64'd0);
        chk("rst_yi", 64'(bus.yi), 64'd0);
        chk("rst_rd_en", 64'(bus.rd_en), 64'd1);

        for (int r = 0; r < 5; r++) begin
            do_reset();
            send(tbl[r].nsym * 64, tbl[r].pat, 0, tbl[r].gappy);
            check_run(tbl[r].name, tbl[r].nsym, tbl[r].contig, tbl[r].exp_n);
            if (tbl[r].nsym >= 3 && !tbl[r].gappy)
                chk({tbl[r].name, "_stalled"}, 64'(stall_cnt > 0), 64'd1);
            if (r == 0) begin
                if (outq.size() > 16) begin
                    chk("single_first_yr", 64'(outq[0].r), 64'd48);
                    chk("single_body0_yr", 64'(outq[16].r), 64'd0);
                end
                chk("cp1_count", 64'(outq1.size()), 64'd65);
                if (outq1.size() == 65 && inq.size() >= 64) begin
                    chk("cp1_first", {41'd0, outq1[0].r, outq1[0].i, outq1[0].s},
                        {41'd0, inq[63], 1'b1});
                    chk("cp1_latency", 64'(outq1[0].e), 64'(acc_e[63] + 2));
                    for (int k = 1; k < 65; k++)
                        chk("cp1_body", {41'd0, outq1[k].r, outq1[k].i, outq1[k].s},
                            {41'd0, inq[k-1], 1'b0});
                end
            end
        end

        do_reset();
        stop_send = 1'b0;
        fork
            send(128, 0, 0, 1'b0);
            begin
                int t;
                t = 0;
                while (outq.size() < 47 && t < 1000) begin
                    @(negedge CLK);
                    t++;
                end
                chk("mid_reached", 64'(outq.size() >= 47), 64'd1);
                #2;
                RST = 1'b0;
                stop_send = 1'b1;
                bus.valid_i = 1'b0;
            end
        join
        #1;
        chk("mid_rst_valid_o", 64'(bus.valid_o), 64'd0);
        chk("mid_rst_sym_o", 64'(bus.sym_o), 64'd0);
        chk("mid_rst_yr", 64'(bus.yr), 64'd0);
        chk("mid_rst_yi", 64'(bus.yi), 64'd0);
        chk("mid_rst_rd_en", 64'(bus.rd_en), 64'd1);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        stop_send = 1'b0;
        clear_q();
        repeat (150) @(posedge CLK);
        #1;
        chk("no_stale_output", 64'(outq.size()), 64'd0);
        send(64, 0, 400, 1'b0);
        check_run("after_reset", 1, 1'b1, 80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cp_insert.md
CP_INSERT -- requirements
Module: cp_insert

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 11, giving the bit width of each I and Q sample.
REQ-002 The block SHALL have a parameter NFFT, default 64, giving the OFDM symbol length in samples; it is fixed at 64 in this release.
REQ-003 The block SHALL have a parameter CP_LEN, default 16, giving the cyclic prefix length; legal range is 1..NFFT-1.
REQ-004 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 RST  input  1  reset; asynchronous and active-low.
REQ-006 valid_i  input  1  IFFT output sample valid.
REQ-007 xr  input  WIDTH  real part of the IFFT sample, two's complement.
REQ-008 xi  input  WIDTH  imaginary part of the IFFT sample, two's complement.
REQ-009 rd_en  output  1  ready toward the IFFT; a sample SHALL be accepted only on an edge where valid_i and rd_en are both 1.
REQ-010 valid_o  output  1  registered output-sample valid, toward the DA offset stage.
REQ-011 yr  output  WIDTH  registered real output sample.
REQ-012 yi  output  WIDTH  registered imaginary output sample.
REQ-013 sym_o  output  1  registered; 1 only on the first cyclic-prefix sample of each output symbol.

Function
REQ-014 Storage SHALL be two NFFT-entry banks (ping-pong), each holding {xr,xi}, with a full flag and a write pointer wbank.
REQ-015 Accepted samples SHALL be written to bank wbank at write index 0..NFFT-1 in arrival order.
REQ-016 On the edge that accepts index NFFT-1, the block SHALL set full[wbank], toggle wbank, and reset the write index to 0.
REQ-017 rd_en SHALL equal !full[wbank] (combinational); samples presented while rd_en=0 SHALL be ignored and not counted.
REQ-018 The read FSM SHALL have states IDLE, CP and BODY, with a read bank pointer rbank.
REQ-019 IDLE: when full[rbank]=1, the FSM SHALL enter CP and issue a read at address NFFT-CP_LEN.
REQ-020 CP: the FSM SHALL issue one read per cycle at addresses NFFT-CP_LEN..NFFT-1, then enter BODY.
REQ-021 BODY: the FSM SHALL issue one read per cycle at addresses 0..NFFT-1.
REQ-022 On the last BODY read, the FSM SHALL clear full[rbank] and toggle rbank.
REQ-023 After the last BODY read, if the other bank is full the FSM SHALL go directly to CP with no idle cycle; otherwise it SHALL go to IDLE.
REQ-024 Each read SHALL produce yr, yi and valid_o=1 on the following edge, so every symbol is NFFT+CP_LEN consecutive valid_o cycles (80 by default).
REQ-025 sym_o SHALL be 1 only with the sample read from address NFFT-CP_LEN while in CP.
REQ-026 Latency from an empty block: valid_o SHALL rise at the second rising edge after the edge that accepted input index NFFT-1.
REQ-027 When valid_o=0, yr and yi SHALL hold their last values.
REQ-028 Data SHALL pass through bit-exact, with no scaling, rounding or saturation.
REQ-029 When both banks are full, rd_en SHALL be 0 and SHALL return to 1 in the cycle after the edge that clears full[rbank].
REQ-030 A write to one bank and a read-side clear of the other bank on the same edge SHALL both take effect.
REQ-031 Sustained throughput SHALL be NFFT input samples per NFFT+CP_LEN cycles, with no output gaps inside a symbol.

Reset
REQ-032 While RST=0, the block SHALL clear full[1:0], wbank, rbank, the write index and the read address, and SHALL force the FSM to IDLE.
REQ-033 While RST=0, valid_o, sym_o, yr and yi SHALL be 0, asynchronously.
REQ-034 Reset asserted mid-symbol SHALL discard all partial and buffered symbols; after release, no output SHALL appear until 64 new samples have been accepted.
REQ-035 Bank memory contents SHALL NOT require reset.

Verification
REQ-036 Single symbol: send 64 contiguous samples xr=k, xi=-k for k=0..63 -> valid_o high for 80 cycles starting 2 edges after the last accept; yr sequence is 48..63 then 0..63; sym_o high only on the first sample (yr=48).
REQ-037 Back-to-back: drive valid_i=1 continuously for 4 symbols -> 320 contiguous valid_o cycles, sym_o every 80 cycles, rd_en dropping while both banks are full, and no sample lost or duplicated.
REQ-038 Backpressure: hold valid_i=1 with full[0]=full[1]=1 -> rd_en=0, input ignored, and rd_en=1 on the cycle after the 64th BODY read of the current bank.
REQ-039 Gappy input: insert random valid_i=0 cycles inside a symbol -> output is identical to the contiguous case, shifted in time only.
REQ-040 Reset mid-operation: assert RST at BODY address 30 of symbol 1 with symbol 2 half-written -> outputs immediately 0; after release, the next 64 accepted samples form the first output symbol.
REQ-041 Extremes: send samples of -1024 and +1023 -> output is bit-exact; with CP_LEN=1, the symbol length is 65 and the first output sample equals input index 63.
